// File: rtl/lut_config_loader.sv
// Bitstream loader for a bank of LUTs: packs WORD_WIDTH-wide words into one
// MEM_SIZE image per LUT and strobes that LUT's cen for a single cycle.
module lut_config_loader #(
   parameter int INPUTS        = 4,
   parameter int MEM_SIZE      = 2**INPUTS,
   parameter int NUM_LUTS      = 4,
   parameter int WORD_WIDTH    = 4,
   parameter int WORDS_PER_LUT = MEM_SIZE / WORD_WIDTH,
   parameter int IDX_W         = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1,
   parameter int CNT_W         = (WORDS_PER_LUT > 1) ? $clog2(WORDS_PER_LUT) : 1
) (
   input  logic                  cclk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [WORD_WIDTH-1:0] word_in,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic [MEM_SIZE-1:0]   config_out,
   output logic [NUM_LUTS-1:0]   cen,
   output logic [IDX_W-1:0]      lut_index,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LUTS - 1);

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [MEM_SIZE-1:0]   shreg_q, shreg_d;
   logic [NUM_LUTS-1:0]   cen_q, cen_d;
   logic                  done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      cen_d   = '0;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               cnt_d   = '0;
               idx_d   = '0;
               done_d  = 1'b0;
            end
         end
         LOAD: begin
            // abort wins over a word offered in the same cycle
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (word_valid) begin
               shreg_d = (shreg_q << WORD_WIDTH) | MEM_SIZE'(word_in);
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = COMMIT;
                  cen_d   = NUM_LUTS'(1) << idx_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         COMMIT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (idx_q == IDX_LAST) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge cclk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         cen_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         cen_q   <= cen_d;
         done_q  <= done_d;
      end
   end

   assign word_ready = (state_q == LOAD);
   assign busy       = (state_q != IDLE);
   assign config_out = shreg_q;
   assign cen        = cen_q;
   assign lut_index  = idx_q;
   assign done       = done_q;

endmodule

// File: tb/tb_lut_config_loader.sv
// Scoreboard bench: expected cen pulses are queued with their cycle number and
// a negedge monitor matches each pulse the loader produces against the queue.
module tb_lut_config_loader;

   logic        cclk = 1'b0;
   logic        reset, start, abort, word_valid;
   logic [3:0]  word_in;
   logic        word_ready, busy, done;
   logic [15:0] config_out;
   logic [3:0]  cen;
   logic [1:0]  lut_index;

   lut_config_loader dut (
      .cclk(cclk), .reset(reset), .start(start), .abort(abort),
      .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
      .config_out(config_out), .cen(cen), .lut_index(lut_index),
      .busy(busy), .done(done)
   );

   always #5 cclk = ~cclk;

   typedef struct {
      int          cyc;
      logic [3:0]  cen;
      logic [15:0] img;
      logic [1:0]  idx;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   s;
   bit   mon_en = 1'b0;

   always @(posedge cclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   task automatic push(input int c, input logic [3:0] ce, input logic [15:0] img, input logic [1:0] idx);
      exp_t e;
      e.cyc = c; e.cen = ce; e.img = img; e.idx = idx;
      exp_q.push_back(e);
   endtask

   // monitor: every cen pulse must match the head of the scoreboard
   always @(negedge cclk) begin
      if (mon_en && cen !== 4'b0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_cen", {28'b0, cen}, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cen", {28'b0, cen}, {28'b0, e.cen});
            chk("config_out", {16'b0, config_out}, {16'b0, e.img});
            chk("lut_index", {30'b0, lut_index}, {30'b0, e.idx});
            chk("cen_cycle", cyc, e.cyc);
            chk("ready_in_commit", {31'b0, word_ready}, 32'h0);
         end
      end
   end

   task automatic tick();
      @(posedge cclk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
   endtask

   // offers one word, waiting (bounded) for word_ready, returns after its edge
   task automatic send_word(input logic [3:0] w);
      int budget = 50;
      while (!word_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (!word_ready) chk("word_ready_timeout", 32'h0, 32'h1);
      word_in = w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   logic [15:0] bank_img [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_in = 4'h0;
      tick(); tick();
      mon_en = 1'b1;
      chk("rst_config_out", {16'b0, config_out}, 32'h0);
      chk("rst_cen", {28'b0, cen}, 32'h0);
      chk("rst_lut_index", {30'b0, lut_index}, 32'h0);
      chk("rst_ready_busy_done", {29'b0, word_ready, busy, done}, 32'h0);
      reset = 1'b0;
      tick();

      // single LUT image, then abandon the rest
      do_start();
      chk("start_busy", {31'b0, busy}, 32'h1);
      push(s + 5, 4'b0001, 16'hABCD, 2'd0);
      send_word(4'hA); send_word(4'hB); send_word(4'hC); send_word(4'hD);
      tick();
      do_abort();
      chk("single_abort_idle", {30'b0, busy, done}, 32'h0);

      // full bank, continuous stream
      tick();
      do_start();
      for (int l = 0; l < 4; l++) push(s + 5 * (l + 1), 4'b0001 << l, bank_img[l], 2'(l));
      for (int i = 0; i < 16; i++) send_word(4'(i));
      tick();
      chk("bank_done", {31'b0, done}, 32'h1);
      chk("bank_busy", {31'b0, busy}, 32'h0);
      chk("bank_cen_clear", {28'b0, cen}, 32'h0);

      // stalls of 3 cycles between words
      do_start();
      chk("start_clears_done", {31'b0, done}, 32'h0);
      push(s + 14, 4'b0001, 16'hABCD, 2'd0);
      send_word(4'hA); repeat (3) tick();
      send_word(4'hB); repeat (3) tick();
      send_word(4'hC); repeat (3) tick();
      send_word(4'hD);
      tick();
      do_abort();

      // abort during LUT 1 with a word offered in the same cycle
      tick();
      do_start();
      push(s + 5, 4'b0001, 16'h0123, 2'd0);
      for (int i = 0; i < 6; i++) send_word(4'(i));
      word_in = 4'h6; word_valid = 1'b1; abort = 1'b1;
      tick();
      word_valid = 1'b0; abort = 1'b0;
      chk("abort_idle", {30'b0, busy, word_ready}, 32'h0);
      chk("abort_word_dropped", {16'b0, config_out}, 32'h2345);
      repeat (3) tick();
      chk("abort_done_low", {31'b0, done}, 32'h0);

      // restart from LUT 0, reset during LUT 2 commit
      do_start();
      chk("restart_index", {30'b0, lut_index}, 32'h0);
      push(s + 5,  4'b0001, 16'hABCD, 2'd0);
      push(s + 10, 4'b0010, 16'h1234, 2'd1);
      push(s + 15, 4'b0100, 16'h5678, 2'd2);
      send_word(4'hA); send_word(4'hB); send_word(4'hC); send_word(4'hD);
      for (int i = 1; i <= 8; i++) send_word(4'(i));
      reset = 1'b1;
      tick();
      chk("midrst_config_out", {16'b0, config_out}, 32'h0);
      chk("midrst_cen_index", {26'b0, cen, lut_index}, 32'h0);
      chk("midrst_flags", {29'b0, word_ready, busy, done}, 32'h0);
      reset = 1'b0;
      repeat (3) tick();

      // start while loading is ignored; sequence completes
      do_start();
      chk("after_rst_index", {30'b0, lut_index}, 32'h0);
      for (int l = 0; l < 4; l++) push(s + 6 + 5 * l, 4'b0001 << l, bank_img[l], 2'(l));
      send_word(4'h0); send_word(4'h1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_start_index", {30'b0, lut_index}, 32'h0);
      for (int i = 2; i < 16; i++) send_word(4'(i));
      tick();
      chk("busy_start_done", {30'b0, done, busy}, 32'h2);
      do_start();
      chk("restart_clears_done", {31'b0, done}, 32'h0);
      do_abort();

      repeat (3) tick();
      chk("scoreboard_empty", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
